// File: rtl/bus_bridge_irq.sv
// Peripheral bus initiator with latched, maskable device interrupts.
// Optional bus-error reporting is enabled by defining BRIDGE_BUSERR_EN.
//
// Ports:
//   CLK_I, RST_I                  clock, async active-high reset
//   PrReq, PrWE, PrAddr, PrWD     CPU request side
//   PrRD, PrRdy, PrBusy           CPU response side
//   DEV_ADD, DEV_WD, DEV_WE       shared device register select / data / strobes
//   DEV0_RD, DEV1_RD, DEV2_RD     per-slot device read data
//   DEV_IRQ                       per-slot single-cycle interrupt pulses
//   HWInt                         to CP0 Cause.IP[7:2]
//
// Map (offset from BASE_ADDR):
//   0x00-0x0B slot0, 0x10-0x1B slot1, 0x20-0x2B slot2,
//   0x30 PEND (write-1-to-clear), 0x34 MASK.
//   Everything else is unmapped.

module bus_bridge_irq #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F00,
    parameter logic [2:0]  MASK_RST  = 3'b111
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic        PrReq,
    input  logic        PrWE,
    input  logic [31:0] PrAddr,
    input  logic [31:0] PrWD,
    output logic [31:0] PrRD,
    output logic        PrRdy,
    output logic        PrBusy,
    output logic [1:0]  DEV_ADD,
    output logic [31:0] DEV_WD,
    output logic [2:0]  DEV_WE,
    input  logic [31:0] DEV0_RD,
    input  logic [31:0] DEV1_RD,
    input  logic [31:0] DEV2_RD,
    input  logic [2:0]  DEV_IRQ,
    output logic [5:0]  HWInt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        RSP  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    // Latched request
    logic [31:0] addr_q;
    logic [31:0] wd_q;
    logic        we_q;

    // Captured response data, presented in RSP
    logic [31:0] rd_q;

    // Interrupt registers
    logic [2:0] pend;
    logic [2:0] mask;

    // Address decode of the latched request
    logic        in_win;
    logic [5:0]  off;
    logic [2:0]  sel_slot;
    logic        sel_pend;
    logic        sel_mask;
    logic        mapped;
    logic        in_acc;
    logic        acc_wr;

    logic [2:0]  pend_clr;
    logic [31:0] pend_rd;
    logic [31:0] rd_mux;

    // BASE_ADDR is 64-byte aligned, so the low six address bits are
    // already the window offset.
    assign in_win = (addr_q[31:6] == BASE_ADDR[31:6]);
    assign off    = addr_q[5:0];

    // Within each 16-byte slot only the first three words exist.
    assign sel_slot[0] = in_win && (off[5:4] == 2'b00) && (off[3:2] != 2'b11);
    assign sel_slot[1] = in_win && (off[5:4] == 2'b01) && (off[3:2] != 2'b11);
    assign sel_slot[2] = in_win && (off[5:4] == 2'b10) && (off[3:2] != 2'b11);
    assign sel_pend    = in_win && (off == 6'h30);
    assign sel_mask    = in_win && (off == 6'h34);
    assign mapped      = (|sel_slot) || sel_pend || sel_mask;

    assign in_acc = (state == ACC);
    assign acc_wr = in_acc && we_q;

    assign pend_clr = (acc_wr && sel_pend) ? wd_q[2:0] : 3'b000;

`ifdef BRIDGE_BUSERR_EN
    // Sticky bus-error flag, reported as PEND bit 3 and HWInt[5].
    logic err;
    logic err_set;
    logic err_clr;

    assign err_set = in_acc && !mapped;
    assign err_clr = acc_wr && sel_pend && wd_q[3];

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            err <= 1'b0;
        end else begin
            // A new error in the same cycle as a clear keeps the flag set.
            err <= err_set || (err && !err_clr);
        end
    end

    assign pend_rd = {28'd0, err, pend};
    assign HWInt   = {err, 2'b00, pend & mask};
`else
    assign pend_rd = {29'd0, pend};
    assign HWInt   = {3'b000, pend & mask};
`endif

    // Read data selection for the latched address
    always_comb begin
        rd_mux = 32'd0;
        unique case (1'b1)
            sel_slot[0]: rd_mux = DEV0_RD;
            sel_slot[1]: rd_mux = DEV1_RD;
            sel_slot[2]: rd_mux = DEV2_RD;
            sel_pend:    rd_mux = pend_rd;
            sel_mask:    rd_mux = {29'd0, mask};
            default:     rd_mux = 32'd0;
        endcase
    end

    // FSM: state register
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM: next state. Requests outside IDLE are ignored.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    state_nxt = PrReq ? ACC : IDLE;
            ACC:     state_nxt = RSP;
            RSP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        PrBusy  = 1'b0;
        PrRdy   = 1'b0;
        PrRD    = 32'd0;
        DEV_ADD = 2'b00;
        DEV_WD  = 32'd0;
        DEV_WE  = 3'b000;
        unique case (state)
            IDLE: begin
                PrBusy = 1'b0;
            end
            ACC: begin
                PrBusy  = 1'b1;
                DEV_ADD = addr_q[3:2];
                DEV_WD  = wd_q;
                DEV_WE  = we_q ? sel_slot : 3'b000;
            end
            RSP: begin
                PrBusy = 1'b1;
                PrRdy  = 1'b1;
                PrRD   = rd_q;
            end
            default: begin
                PrBusy = 1'b0;
            end
        endcase
    end

    // Request capture and response data
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            addr_q <= 32'd0;
            wd_q   <= 32'd0;
            we_q   <= 1'b0;
            rd_q   <= 32'd0;
        end else begin
            if ((state == IDLE) && PrReq) begin
                addr_q <= PrAddr;
                wd_q   <= PrWD;
                we_q   <= PrWE;
            end
            if (in_acc) begin
                rd_q <= we_q ? 32'd0 : rd_mux;
            end
        end
    end

    // Interrupt pending / mask registers
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            pend <= 3'b000;
            mask <= MASK_RST;
        end else begin
            // Incoming pulses win over a simultaneous clear.
            pend <= (pend & ~pend_clr) | DEV_IRQ;
            if (acc_wr && sel_mask) begin
                mask <= wd_q[2:0];
            end
        end
    end

endmodule

// File: tb/tb_bus_bridge_irq.sv
// Scoreboarded bench for bus_bridge_irq.
// Define BRIDGE_BUSERR_EN to also exercise the bus-error flag.

module tb_bus_bridge_irq;

    localparam logic [31:0] BASE = 32'h0000_7F00;

    logic        CLK_I;
    logic        RST_I;
    logic        PrReq;
    logic        PrWE;
    logic [31:0] PrAddr;
    logic [31:0] PrWD;
    logic [31:0] PrRD;
    logic        PrRdy;
    logic        PrBusy;
    logic [1:0]  DEV_ADD;
    logic [31:0] DEV_WD;
    logic [2:0]  DEV_WE;
    logic [31:0] DEV0_RD;
    logic [31:0] DEV1_RD;
    logic [31:0] DEV2_RD;
    logic [2:0]  DEV_IRQ;
    logic [5:0]  HWInt;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];

    bus_bridge_irq dut (
        .CLK_I  (CLK_I),
        .RST_I  (RST_I),
        .PrReq  (PrReq),
        .PrWE   (PrWE),
        .PrAddr (PrAddr),
        .PrWD   (PrWD),
        .PrRD   (PrRD),
        .PrRdy  (PrRdy),
        .PrBusy (PrBusy),
        .DEV_ADD(DEV_ADD),
        .DEV_WD (DEV_WD),
        .DEV_WE (DEV_WE),
        .DEV0_RD(DEV0_RD),
        .DEV1_RD(DEV1_RD),
        .DEV2_RD(DEV2_RD),
        .DEV_IRQ(DEV_IRQ),
        .HWInt  (HWInt)
    );

    initial CLK_I = 1'b0;
    always #5 CLK_I = ~CLK_I;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: every completed access is compared against the scoreboard.
    always @(negedge CLK_I) begin : monitor
        logic [31:0] e;
        if (PrRdy === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_prrdy: got PrRD=%h, expected no response",
                         PrRD);
            end else begin
                e = exp_q.pop_front();
                chk("prrd", PrRD, e);
            end
        end
    end

    // One bus access. irq_acc is driven on DEV_IRQ during the ACC cycle.
    task automatic access(input logic we, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] exp_rd,
                          input logic [2:0] exp_we, input logic [1:0] exp_add,
                          input logic [2:0] irq_acc);
        @(posedge CLK_I);
        #1;
        PrReq  = 1'b1;
        PrWE   = we;
        PrAddr = addr;
        PrWD   = wd;
        exp_q.push_back(exp_rd);
        @(posedge CLK_I);
        #1;
        PrReq   = 1'b0;
        DEV_IRQ = irq_acc;
        @(negedge CLK_I);
        chk("acc_dev_we", {29'd0, DEV_WE}, {29'd0, exp_we});
        chk("acc_dev_add", {30'd0, DEV_ADD}, {30'd0, exp_add});
        chk("acc_busy_rdy", {30'd0, PrBusy, PrRdy}, 32'd2);
        if (we) chk("acc_dev_wd", DEV_WD, wd);
        @(posedge CLK_I);
        #1;
        DEV_IRQ = 3'b000;
        @(negedge CLK_I);
        chk("rsp_rdy_we", {28'd0, PrRdy, DEV_WE}, 32'h8);
    endtask

    task automatic pulse_irq(input logic [2:0] v);
        @(posedge CLK_I);
        #1;
        DEV_IRQ = v;
        @(posedge CLK_I);
        #1;
        DEV_IRQ = 3'b000;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin : stim
        RST_I   = 1'b1;
        PrReq   = 1'b0;
        PrWE    = 1'b0;
        PrAddr  = 32'd0;
        PrWD    = 32'd0;
        DEV0_RD = 32'h1111_1111;
        DEV1_RD = 32'h2222_2222;
        DEV2_RD = 32'h0;
        DEV_IRQ = 3'b000;
        repeat (3) @(posedge CLK_I);
        #1;
        RST_I = 1'b0;

        // Reset state
        @(negedge CLK_I);
        chk("rst_ctrl", {29'd0, PrRdy, PrBusy, |DEV_WE}, 32'd0);
        chk("rst_prrd", PrRD, 32'd0);
        chk("rst_dev", {DEV_WD[29:0], DEV_ADD}, 32'd0);
        chk("rst_hwint", {26'd0, HWInt}, 32'd0);
        access(1'b0, BASE + 32'h34, 32'd0, 32'd7, 3'b000, 2'b01, 3'b000);

        // Slot write and reads
        access(1'b1, BASE + 32'h10, 32'd9, 32'd0, 3'b010, 2'b00, 3'b000);
        DEV2_RD = 32'hDEAD_BEEF;
        access(1'b0, BASE + 32'h28, 32'd0, 32'hDEAD_BEEF, 3'b000, 2'b10, 3'b000);
        access(1'b0, BASE + 32'h14, 32'd0, 32'h2222_2222, 3'b000, 2'b01, 3'b000);
        access(1'b1, BASE + 32'h08, 32'hA5A5_0001, 32'd0, 3'b001, 2'b10, 3'b000);

        // IRQ latch and W1C
        pulse_irq(3'b001);
        @(negedge CLK_I);
        chk("irq0_set", {26'd0, HWInt}, 32'd1);
        @(negedge CLK_I);
        chk("irq0_held", {26'd0, HWInt}, 32'd1);
        access(1'b1, BASE + 32'h30, 32'd1, 32'd0, 3'b000, 2'b00, 3'b000);
        chk("irq0_clr", {26'd0, HWInt}, 32'd0);

        // Masking and set-wins
        access(1'b1, BASE + 32'h34, 32'd0, 32'd0, 3'b000, 2'b01, 3'b000);
        pulse_irq(3'b010);
        @(negedge CLK_I);
        chk("irq1_masked", {26'd0, HWInt}, 32'd0);
        access(1'b0, BASE + 32'h30, 32'd0, 32'd2, 3'b000, 2'b00, 3'b000);
        access(1'b1, BASE + 32'h30, 32'd2, 32'd0, 3'b000, 2'b00, 3'b010);
        access(1'b0, BASE + 32'h30, 32'd0, 32'd2, 3'b000, 2'b00, 3'b000);
        access(1'b1, BASE + 32'h30, 32'd2, 32'd0, 3'b000, 2'b00, 3'b000);
        access(1'b0, BASE + 32'h30, 32'd0, 32'd0, 3'b000, 2'b00, 3'b000);

        // Unmapped read at 0x3C
        access(1'b0, BASE + 32'h3C, 32'd0, 32'd0, 3'b000, 2'b11, 3'b000);
`ifdef BRIDGE_BUSERR_EN
        chk("err_hwint", {26'd0, HWInt}, 32'h20);
        access(1'b0, BASE + 32'h30, 32'd0, 32'd8, 3'b000, 2'b00, 3'b000);
        access(1'b1, BASE + 32'h30, 32'd8, 32'd0, 3'b000, 2'b00, 3'b000);
        chk("err_clr", {26'd0, HWInt}, 32'd0);
`else
        chk("unmapped_hwint", {26'd0, HWInt}, 32'd0);
        access(1'b0, BASE + 32'h30, 32'd0, 32'd0, 3'b000, 2'b00, 3'b000);
`endif

        // Held request: two accesses, ready on cycles 2 and 5
        access(1'b1, BASE + 32'h34, 32'd5, 32'd0, 3'b000, 2'b01, 3'b000);
        @(posedge CLK_I);
        #1;
        PrReq  = 1'b1;
        PrWE   = 1'b0;
        PrAddr = BASE + 32'h34;
        exp_q.push_back(32'd5);
        exp_q.push_back(32'd5);
        for (int k = 0; k < 6; k++) begin
            @(negedge CLK_I);
            chk($sformatf("held_rdy_c%0d", k), {31'd0, PrRdy},
                {31'd0, (k == 2 || k == 5)});
        end
        @(posedge CLK_I);
        #1;
        PrReq = 1'b0;
        @(negedge CLK_I);
        chk("held_idle", {30'd0, PrBusy, PrRdy}, 32'd0);

        // Other unmapped accesses
        access(1'b1, BASE + 32'h0C, 32'h77, 32'd0, 3'b000, 2'b11, 3'b000);
        access(1'b0, 32'h0000_8000, 32'd0, 32'd0, 3'b000, 2'b00, 3'b000);
`ifdef BRIDGE_BUSERR_EN
        chk("err_again", {26'd0, HWInt}, 32'h20);
`else
        chk("unmapped_quiet", {26'd0, HWInt}, 32'd0);
`endif

        // Reset during ACC aborts the access
        @(posedge CLK_I);
        #1;
        PrReq  = 1'b1;
        PrWE   = 1'b1;
        PrAddr = BASE;
        PrWD   = 32'h55;
        @(posedge CLK_I);
        #1;
        PrReq = 1'b0;
        @(negedge CLK_I);
        chk("pre_rst_we", {29'd0, DEV_WE}, 32'd1);
        #1;
        RST_I = 1'b1;
        #1;
        chk("mid_rst", {28'd0, PrBusy, DEV_WE}, 32'd0);
        @(posedge CLK_I);
        #1;
        RST_I = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK_I);
            chk($sformatf("post_rst_c%0d", k), {28'd0, PrRdy, DEV_WE}, 32'd0);
        end
        chk("post_rst_hwint", {26'd0, HWInt}, 32'd0);
        access(1'b0, BASE + 32'h34, 32'd0, 32'd7, 3'b000, 2'b01, 3'b000);

        repeat (2) @(negedge CLK_I);
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
